// File: rtl/noise_est_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noise_est_pkg
// Brief    : Shared FSM state type and default geometry for the noise estimator.
// Revision : 1.0
// ============================================================================
package noise_est_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_MEAN = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_WAIT_VAR  = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_e;

    localparam int DEFAULT_TOTAL_SAMPLES    = 64;
    localparam int DEFAULT_BLOCKS_PER_FRAME = 2;

endpackage
`default_nettype wire

// File: rtl/sample_counter.sv
`default_nettype none
// ============================================================================
// Module   : sample_counter
// Brief    : Modulo-MODULUS up-counter with clear, enable and terminal flag.
// Revision : 1.0
// ============================================================================
module sample_counter
    import noise_est_pkg::*;
#(
    parameter int MODULUS = 4,
    parameter int WIDTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);

    localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST_VAL) ? '0 : count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LAST_VAL);

endmodule
`default_nettype wire

// File: rtl/noise_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : noise_block_sequencer
// Brief    : Sequences block fill, mean wait, variance drain and frame averaging.
// Revision : 1.0
// ============================================================================
module noise_block_sequencer
    import noise_est_pkg::*;
#(
    parameter int TOTAL_SAMPLES    = DEFAULT_TOTAL_SAMPLES,
    parameter int BLOCKS_PER_FRAME = DEFAULT_BLOCKS_PER_FRAME
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_of_frame,
    input  logic                                end_of_frame,
    input  logic                                pixel_valid,
    output logic                                pixel_ready,
    input  logic                                mean_ready,
    input  logic                                variance_ready,
    output logic                                mean_start,
    output logic                                shift_en,
    output logic                                shift_reg_clr,
    output logic                                variance_start,
    output logic                                noise_mean_en,
    output logic [$clog2(BLOCKS_PER_FRAME):0]   block_idx,
    output logic                                frame_done,
    output logic                                frame_error
);

    localparam int SW = $clog2(TOTAL_SAMPLES);
    localparam int BW = $clog2(BLOCKS_PER_FRAME) + 1;
    localparam logic [BW-1:0] LAST_BLOCK = BW'(BLOCKS_PER_FRAME - 1);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       frame_error_q;
    logic       frame_error_d;

    logic          w_smp_clr;
    logic          w_smp_en;
    logic          w_smp_last;
    logic [SW-1:0] w_smp_cnt;
    logic          w_blk_clr;
    logic          w_blk_en;
    logic          w_blk_sat;
    logic [BW-1:0] w_blk_cnt;
    logic          w_active;

    // The sample counter also times the drain, since it wraps to 0 at the end of fill.
    sample_counter #(
        .MODULUS (TOTAL_SAMPLES),
        .WIDTH   (SW)
    ) u_sample_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_smp_clr),
        .en_i    (w_smp_en),
        .count_o (w_smp_cnt),
        .last_o  (w_smp_last)
    );

    // One extra count lets the index reach BLOCKS_PER_FRAME and hold there.
    sample_counter #(
        .MODULUS (BLOCKS_PER_FRAME + 1),
        .WIDTH   (BW)
    ) u_block_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_blk_clr),
        .en_i    (w_blk_en),
        .count_o (w_blk_cnt),
        .last_o  (w_blk_sat)
    );

    assign w_active = (state_q == ST_FILL) || (state_q == ST_WAIT_MEAN) ||
                      (state_q == ST_DRAIN) || (state_q == ST_WAIT_VAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        frame_error_d  = frame_error_q;
        mean_start     = 1'b0;
        shift_en       = 1'b0;
        shift_reg_clr  = 1'b0;
        variance_start = 1'b0;
        noise_mean_en  = 1'b0;
        frame_done     = 1'b0;
        w_smp_clr      = 1'b0;
        w_smp_en       = 1'b0;
        w_blk_clr      = 1'b0;
        w_blk_en       = 1'b0;

        if (start_of_frame) begin
            shift_reg_clr = 1'b1;
            w_smp_clr     = 1'b1;
            w_blk_clr     = 1'b1;
            state_d       = ST_FILL;
            if (state_q == ST_IDLE) begin
                frame_error_d = 1'b0;
            end
        end else if (end_of_frame && w_active) begin
            shift_reg_clr = 1'b1;
            w_smp_clr     = 1'b1;
            w_blk_clr     = 1'b1;
            frame_error_d = 1'b1;
            state_d       = ST_IDLE;
        end else begin
            case (state_q)
                ST_FILL: begin
                    shift_en   = pixel_valid;
                    mean_start = pixel_valid && (w_smp_cnt == '0);
                    w_smp_en   = pixel_valid;
                    if (pixel_valid && w_smp_last) begin
                        state_d = mean_ready ? ST_DRAIN : ST_WAIT_MEAN;
                    end
                end
                ST_WAIT_MEAN: begin
                    if (mean_ready) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    shift_en       = 1'b1;
                    variance_start = (w_smp_cnt == '0);
                    w_smp_en       = 1'b1;
                    if (w_smp_last) begin
                        state_d = ST_WAIT_VAR;
                    end
                end
                ST_WAIT_VAR: begin
                    if (variance_ready) begin
                        noise_mean_en = 1'b1;
                        w_blk_en      = !w_blk_sat;
                        if (w_blk_cnt == LAST_BLOCK) begin
                            state_d = ST_DONE;
                        end else begin
                            shift_reg_clr = 1'b1;
                            state_d       = ST_FILL;
                        end
                    end
                end
                ST_DONE: begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Moore decode only: mean/variance handshakes never reach pixel_ready.
    assign pixel_ready = (state_q == ST_FILL);
    assign block_idx   = w_blk_cnt;
    assign frame_error = frame_error_q;

endmodule
`default_nettype wire

// File: tb/tb_noise_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_noise_block_sequencer
// Brief    : Scoreboard bench for noise_block_sequencer (4 samples, 2 blocks).
// Revision : 1.0
// ============================================================================
module tb_noise_block_sequencer;

    localparam int N = 4;
    localparam int B = 2;

    typedef struct packed {
        logic       clr;
        logic       ms;
        logic       se;
        logic       vs;
        logic       nme;
        logic       fd;
        logic [1:0] idx;
        logic       ferr;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_of_frame = 1'b0;
    logic       end_of_frame = 1'b0;
    logic       pixel_valid = 1'b0;
    logic       mean_ready = 1'b0;
    logic       variance_ready = 1'b0;
    logic       pixel_ready;
    logic       mean_start;
    logic       shift_en;
    logic       shift_reg_clr;
    logic       variance_start;
    logic       noise_mean_en;
    logic [1:0] block_idx;
    logic       frame_done;
    logic       frame_error;

    int  total = 0;
    int  bad = 0;
    int  m_idx = 0;
    bit  m_ferr = 1'b0;
    ev_t exp_q[$];

    noise_block_sequencer #(
        .TOTAL_SAMPLES    (N),
        .BLOCKS_PER_FRAME (B)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_of_frame (start_of_frame),
        .end_of_frame   (end_of_frame),
        .pixel_valid    (pixel_valid),
        .pixel_ready    (pixel_ready),
        .mean_ready     (mean_ready),
        .variance_ready (variance_ready),
        .mean_start     (mean_start),
        .shift_en       (shift_en),
        .shift_reg_clr  (shift_reg_clr),
        .variance_start (variance_start),
        .noise_mean_en  (noise_mean_en),
        .block_idx      (block_idx),
        .frame_done     (frame_done),
        .frame_error    (frame_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input bit clr, input bit ms, input bit se,
                             input bit vs, input bit nme, input bit fd);
        ev_t e;
        e.clr  = clr;
        e.ms   = ms;
        e.se   = se;
        e.vs   = vs;
        e.nme  = nme;
        e.fd   = fd;
        e.idx  = 2'(m_idx);
        e.ferr = m_ferr;
        exp_q.push_back(e);
    endtask

    task automatic do_sof(input bit from_idle);
        start_of_frame = 1'b1;
        expect_ev(1, 0, 0, 0, 0, 0);
        cyc();
        start_of_frame = 1'b0;
        m_idx = 0;
        if (from_idle) m_ferr = 1'b0;
    endtask

    task automatic feed(input int n, input bit early, input bit hold);
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1;
            expect_ev(0, (i == 0), 1, 0, 0, 0);
            if (early && i == n - 1) mean_ready = 1'b1;
            cyc();
            mean_ready = 1'b0;
        end
        if (!hold) pixel_valid = 1'b0;
    endtask

    task automatic wait_mean(input int gap);
        for (int i = 0; i < gap; i++) begin
            check("wait_mean_pixel_ready", 32'(pixel_ready), 0);
            cyc();
        end
        mean_ready = 1'b1;
        check("wait_mean_pixel_ready", 32'(pixel_ready), 0);
        cyc();
        mean_ready = 1'b0;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            expect_ev(0, 0, 1, (i == 0), 0, 0);
            check("drain_shift_en", 32'(shift_en), 1);
            check("drain_pixel_ready", 32'(pixel_ready), 0);
            cyc();
        end
    endtask

    task automatic wait_var(input int gap, input bit last);
        for (int i = 0; i < gap; i++) begin
            check("wait_var_pixel_ready", 32'(pixel_ready), 0);
            check("wait_var_idle_nme", 32'(noise_mean_en), 0);
            cyc();
        end
        variance_ready = 1'b1;
        expect_ev(!last, 0, 0, 0, 1, 0);
        cyc();
        variance_ready = 1'b0;
        m_idx++;
        if (last) begin
            expect_ev(0, 0, 0, 0, 0, 1);
            cyc();
        end
    endtask

    task automatic run_block(input bit last, input bit hold);
        feed(N, 0, hold);
        wait_mean(2);
        drain(N);
        wait_var(3, last);
    endtask

    // Monitor: any pulse or shift is an output event and must match the queue head.
    initial begin
        ev_t act;
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst && (shift_reg_clr || mean_start || shift_en || variance_start ||
                         noise_mean_en || frame_done)) begin
                act.clr  = shift_reg_clr;
                act.ms   = mean_start;
                act.se   = shift_en;
                act.vs   = variance_start;
                act.nme  = noise_mean_en;
                act.fd   = frame_done;
                act.idx  = block_idx;
                act.ferr = frame_error;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got %b expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        bad++;
                        $display("FAIL event: got clr/ms/se/vs/nme/fd/idx/ferr=%b expected %b", act, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) cyc();
        check("reset_outputs",
              {25'd0, pixel_ready, shift_en, shift_reg_clr, mean_start,
               variance_start, noise_mean_en, frame_done}, 0);
        check("reset_block_idx", 32'(block_idx), 0);
        check("reset_frame_error", 32'(frame_error), 0);
        rst = 1'b0;

        // Nominal two-block frame
        do_sof(1);
        check("fill_pixel_ready", 32'(pixel_ready), 1);
        check("fill_block_idx", 32'(block_idx), 0);
        run_block(0, 0);
        check("block1_idx", 32'(block_idx), 1);
        run_block(1, 0);
        check("done_idx_no_wrap", 32'(block_idx), 2);
        check("idle_pixel_ready", 32'(pixel_ready), 0);
        check("nominal_frame_error", 32'(frame_error), 0);

        // pixel_valid held high throughout the frame
        do_sof(1);
        run_block(0, 1);
        run_block(1, 1);
        check("bp_idle_pixel_ready", 32'(pixel_ready), 0);
        pixel_valid = 1'b0;

        // Short frame, then ignored strobes in IDLE
        do_sof(1);
        feed(3, 0, 0);
        end_of_frame = 1'b1;
        expect_ev(1, 0, 0, 0, 0, 0);
        cyc();
        end_of_frame = 1'b0;
        m_ferr = 1'b1;
        check("short_frame_error", 32'(frame_error), 1);
        check("short_idle_pixel_ready", 32'(pixel_ready), 0);
        repeat (3) cyc();
        end_of_frame = 1'b1;
        mean_ready = 1'b1;
        cyc();
        end_of_frame = 1'b0;
        mean_ready = 1'b0;
        check("eof_idle_ignored", 32'(frame_error), 1);
        check("stray_mean_idle_ready", 32'(pixel_ready), 0);

        // Early mean_ready on the last pixel goes straight to DRAIN
        do_sof(1);
        check("sof_clears_error", 32'(frame_error), 0);
        feed(N, 1, 0);
        drain(N);
        wait_var(0, 0);
        feed(N, 0, 0);
        wait_mean(0);
        drain(N);
        wait_var(0, 1);

        // Restart during DRAIN of block 0
        do_sof(1);
        feed(N, 0, 0);
        wait_mean(1);
        drain(2);
        do_sof(0);
        check("restart_pixel_ready", 32'(pixel_ready), 1);
        check("restart_block_idx", 32'(block_idx), 0);
        run_block(0, 0);
        run_block(1, 0);

        // Reset in WAIT_VAR, then a stray variance_ready
        do_sof(1);
        feed(N, 0, 0);
        wait_mean(0);
        drain(N);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_idx = 0;
        m_ferr = 1'b0;
        check("post_reset_outputs",
              {25'd0, pixel_ready, shift_en, shift_reg_clr, mean_start,
               variance_start, noise_mean_en, frame_done}, 0);
        check("post_reset_idx_err", {29'd0, block_idx, frame_error}, 0);
        variance_ready = 1'b1;
        #1;
        check("stray_var_ready_nme", 32'(noise_mean_en), 0);
        cyc();
        variance_ready = 1'b0;
        repeat (4) cyc();
        check("post_reset_frame_done", 32'(frame_done), 0);

        repeat (2) cyc();
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
